// File: rtl/cic_decim_n.sv
// N-stage CIC decimator with runtime-programmable ratio and gain shift.
// The output is rounded and saturated, and the first tokens after a flush are suppressed.
module cic_decim_n #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned OUT_WIDTH   = 16,
    parameter int unsigned NUM_STAGES  = 5,
    parameter int unsigned DIFF_DELAY  = 1,
    parameter int unsigned MAX_RATIO   = 64,
    parameter int unsigned RATIO_WIDTH = 7,
    parameter int unsigned ACC_WIDTH   = DATA_WIDTH + NUM_STAGES * $clog2(MAX_RATIO * DIFF_DELAY)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic signed [DATA_WIDTH-1:0]  data_in,
    input  logic                          cfg_load,
    input  logic        [RATIO_WIDTH-1:0] dec_ratio,
    input  logic        [5:0]             out_shift,
    output logic                          out_valid,
    output logic signed [OUT_WIDTH-1:0]   data_out,
    output logic                          sat_flag,
    output logic                          cfg_err
);

    localparam int unsigned WarmTokens = NUM_STAGES * DIFF_DELAY;
    localparam int unsigned WarmW      = $clog2(WarmTokens + 1);
    localparam logic [RATIO_WIDTH-1:0] RatioMax = RATIO_WIDTH'(MAX_RATIO);
    localparam logic [RATIO_WIDTH-1:0] RatioOne = RATIO_WIDTH'(1);
    localparam logic [5:0]             ShiftMax = 6'(ACC_WIDTH - 1);
    localparam logic signed [ACC_WIDTH:0] RndOne = (ACC_WIDTH + 1)'(1);
    localparam logic signed [ACC_WIDTH:0] OutMax =
        {{(ACC_WIDTH - OUT_WIDTH + 2){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] OutMin =
        {{(ACC_WIDTH - OUT_WIDTH + 2){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

    typedef logic signed [ACC_WIDTH-1:0] acc_t;

    logic flush;
    assign flush = rst | cfg_load;

    // Configuration
    logic [RATIO_WIDTH-1:0] ratio_q;
    logic [5:0]             shift_q;
    logic                   cfg_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ratio_q   <= RatioMax;
            shift_q   <= '0;
            cfg_err_q <= 1'b0;
        end else if (cfg_load) begin
            if (dec_ratio == '0) begin
                ratio_q   <= RatioOne;
                cfg_err_q <= 1'b1;
            end else if (dec_ratio > RatioMax) begin
                ratio_q   <= RatioMax;
                cfg_err_q <= 1'b1;
            end else begin
                ratio_q   <= dec_ratio;
                cfg_err_q <= 1'b0;
            end
            shift_q <= (out_shift > ShiftMax) ? ShiftMax : out_shift;
        end
    end

    // Integrators and decimation counter
    acc_t                   integ_q [NUM_STAGES];
    acc_t                   integ_d [NUM_STAGES];
    logic [RATIO_WIDTH-1:0] cnt_q;
    acc_t                   tap_q;
    logic                   tap_vld_q;
    logic                   dec_hit;

    assign dec_hit = in_valid && (cnt_q == ratio_q - RatioOne);

    always_comb begin
        integ_d[0] = integ_q[0] + acc_t'(data_in);
        for (int k = 1; k < NUM_STAGES; k++) begin
            integ_d[k] = integ_q[k] + integ_q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            for (int k = 0; k < NUM_STAGES; k++) integ_q[k] <= '0;
            cnt_q     <= '0;
            tap_q     <= '0;
            tap_vld_q <= 1'b0;
        end else begin
            tap_vld_q <= dec_hit;
            if (in_valid) begin
                integ_q <= integ_d;
                cnt_q   <= dec_hit ? '0 : cnt_q + RatioOne;
                if (dec_hit) tap_q <= integ_d[NUM_STAGES-1];
            end
        end
    end

    // Comb pipeline: one register per stage, delay lines shift only on a token
    acc_t                  comb_x  [NUM_STAGES];
    logic [NUM_STAGES-1:0] comb_xv;
    acc_t                  diff_q  [NUM_STAGES];
    logic [NUM_STAGES-1:0] vld_q;
    acc_t                  dly_q   [NUM_STAGES][DIFF_DELAY];

    always_comb begin
        comb_xv    = '0;
        comb_x[0]  = tap_q;
        comb_xv[0] = tap_vld_q;
        for (int k = 1; k < NUM_STAGES; k++) begin
            comb_x[k]  = diff_q[k-1];
            comb_xv[k] = vld_q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            vld_q <= '0;
            for (int k = 0; k < NUM_STAGES; k++) begin
                diff_q[k] <= '0;
                for (int i = 0; i < DIFF_DELAY; i++) dly_q[k][i] <= '0;
            end
        end else begin
            vld_q <= comb_xv;
            for (int k = 0; k < NUM_STAGES; k++) begin
                if (comb_xv[k]) begin
                    diff_q[k]   <= comb_x[k] - dly_q[k][DIFF_DELAY-1];
                    dly_q[k][0] <= comb_x[k];
                    for (int i = 1; i < DIFF_DELAY; i++) dly_q[k][i] <= dly_q[k][i-1];
                end
            end
        end
    end

    // Output scaling, saturation and warm-up suppression
    acc_t                         comb_out;
    logic                         comb_vld;
    logic signed [ACC_WIDTH:0]    rnd_sum;
    logic signed [ACC_WIDTH:0]    scaled;
    logic signed [OUT_WIDTH-1:0]  sat_val;
    logic                         sat_hit;
    logic [WarmW-1:0]             warm_q;
    logic                         warm_done;
    logic                         emit;
    logic                         out_valid_q;
    logic signed [OUT_WIDTH-1:0]  data_out_q;
    logic                         sat_q;

    assign comb_out  = diff_q[NUM_STAGES-1];
    assign comb_vld  = vld_q[NUM_STAGES-1];
    assign warm_done = (warm_q == WarmW'(WarmTokens));
    assign emit      = comb_vld && warm_done;

    always_comb begin
        rnd_sum = {comb_out[ACC_WIDTH-1], comb_out};
        if (shift_q != '0) rnd_sum = rnd_sum + (RndOne <<< (shift_q - 6'd1));
        scaled  = rnd_sum >>> shift_q;
        sat_hit = 1'b0;
        sat_val = scaled[OUT_WIDTH-1:0];
        if (scaled > OutMax) begin
            sat_val = OutMax[OUT_WIDTH-1:0];
            sat_hit = 1'b1;
        end else if (scaled < OutMin) begin
            sat_val = OutMin[OUT_WIDTH-1:0];
            sat_hit = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            warm_q      <= '0;
            out_valid_q <= 1'b0;
            data_out_q  <= '0;
            sat_q       <= 1'b0;
        end else begin
            out_valid_q <= emit;
            if (comb_vld && !warm_done) warm_q <= warm_q + WarmW'(1);
            if (emit) begin
                data_out_q <= sat_val;
                if (sat_hit) sat_q <= 1'b1;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign data_out  = data_out_q;
    assign sat_flag  = sat_q;
    assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_cic_decim_n.sv
// Bench for cic_decim_n: a sample-level CIC model predicts every output cycle,
// and directed scenarios pin the model with hand-derived values.
module tb_cic_decim_n;
    localparam int N = 5;
    localparam int M = 1;
    localparam int AW = 46;
    localparam int MAXR = 64;
    localparam int MaxCyc = 4096;

    logic clk = 1'b0;
    logic rst, in_valid, cfg_load, out_valid, sat_flag, cfg_err;
    logic signed [15:0] data_in, data_out;
    logic [6:0] dec_ratio;
    logic [5:0] out_shift;

    always #5 clk = ~clk;

    cic_decim_n dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(data_in), .cfg_load(cfg_load),
        .dec_ratio(dec_ratio), .out_shift(out_shift), .out_valid(out_valid),
        .data_out(data_out), .sat_flag(sat_flag), .cfg_err(cfg_err)
    );

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;

    // Expected events indexed by the cycle in which they become visible / occur
    bit     emit_v [MaxCyc];
    bit     emit_s [MaxCyc];
    longint emit_d [MaxCyc];
    bit     clr_ev [MaxCyc];
    bit     rst_ev [MaxCyc];
    bit     err_ev [MaxCyc];

    logic signed [AW-1:0] m_int [N];
    logic signed [AW-1:0] m_dly [N][M];
    int m_cnt, m_warm, m_ratio, m_shift;

    int     obs_t [$];
    longint obs_d [$];

    function automatic void check(string nm, logic signed [63:0] act, logic signed [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endfunction

    function automatic void m_clear(int c);
        for (int s = 0; s < N; s++) begin
            m_int[s] = '0;
            for (int i = 0; i < M; i++) m_dly[s][i] = '0;
        end
        m_cnt = 0;
        m_warm = 0;
        for (int t = c + 1; t <= c + N + 2 && t < MaxCyc; t++) emit_v[t] = 1'b0;
        clr_ev[c] = 1'b1;
    endfunction

    function automatic void m_token(logic signed [AW-1:0] tap, int t);
        logic signed [AW-1:0] x, y;
        longint v;
        x = tap;
        for (int s = 0; s < N; s++) begin
            y = x - m_dly[s][M-1];
            for (int i = M - 1; i > 0; i--) m_dly[s][i] = m_dly[s][i-1];
            m_dly[s][0] = x;
            x = y;
        end
        if (m_warm < N * M) begin
            m_warm++;
            return;
        end
        v = longint'(x);
        if (m_shift > 0) v = (v + (64'sd1 <<< (m_shift - 1))) >>> m_shift;
        emit_s[t] = 1'b0;
        if (v > 32767) begin
            v = 32767;
            emit_s[t] = 1'b1;
        end else if (v < -32768) begin
            v = -32768;
            emit_s[t] = 1'b1;
        end
        emit_v[t] = 1'b1;
        emit_d[t] = v;
    endfunction

    task automatic step(input bit r, input bit cl, input bit v, input int d, input int ratio,
                        input int shift);
        logic signed [15:0] ds;
        ds = v ? 16'(d) : 16'($urandom);
        rst = r; cfg_load = cl; in_valid = v; data_in = ds;
        dec_ratio = cl ? 7'(ratio) : 7'($urandom);
        out_shift = cl ? 6'(shift) : 6'($urandom);
        if (r) begin
            m_ratio = MAXR; m_shift = 0;
            m_clear(cyc);
            rst_ev[cyc] = 1'b1;
        end else if (cl) begin
            err_ev[cyc] = (ratio == 0) || (ratio > MAXR);
            m_ratio = (ratio == 0) ? 1 : (ratio > MAXR) ? MAXR : ratio;
            m_shift = (shift >= AW) ? AW - 1 : shift;
            m_clear(cyc);
        end else if (v) begin
            for (int s = N - 1; s > 0; s--) m_int[s] = m_int[s] + m_int[s-1];
            m_int[0] = m_int[0] + ds;
            m_cnt++;
            if (m_cnt == m_ratio) begin
                m_cnt = 0;
                m_token(m_int[N-1], cyc + N + 2);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic run(input int n, input int d, input int gap);
        repeat (n) begin
            step(0, 0, 1, d, 0, 0);
            idle(gap - 1);
        end
    endtask

    task automatic cfg(input int r, input int s);
        step(0, 1, 1, $urandom, r, s);
    endtask

    task automatic chk_obs(input string nm, input int cnt, input longint val, input int gap);
        check({nm, "_count"}, obs_d.size(), cnt);
        foreach (obs_d[i]) check({nm, "_data"}, obs_d[i], val);
        for (int i = 1; i < obs_t.size(); i++) check({nm, "_spacing"}, obs_t[i] - obs_t[i-1], gap);
    endtask

    // Per-cycle comparison against the model
    initial begin
        bit chk_en;
        longint m_dout;
        bit m_sat, m_err;
        int c;
        chk_en = 0; m_dout = 0; m_sat = 0; m_err = 0;
        forever begin
            @(negedge clk);
            c = cyc;
            if (c > 0 && c < MaxCyc && clr_ev[c-1]) begin
                m_dout = 0;
                m_sat = 0;
                m_err = rst_ev[c-1] ? 1'b0 : err_ev[c-1];
                if (rst_ev[c-1]) chk_en = 1;
            end
            if (chk_en && c < MaxCyc) begin
                if (emit_v[c]) begin
                    m_dout = emit_d[c];
                    if (emit_s[c]) m_sat = 1;
                end
                check("out_valid", out_valid, emit_v[c]);
                check("data_out", data_out, m_dout);
                check("sat_flag", sat_flag, m_sat);
                check("cfg_err", cfg_err, m_err);
                if (out_valid === 1'b1) begin
                    obs_t.push_back(c);
                    obs_d.push_back(data_out);
                end
            end
        end
    end

    initial begin
        int c0;
        int cc;
        int imp [11];
        longint sum;
        imp = '{0, 0, 35, 155, 65, 1, 0, 0, 0, 0, 0};

        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 1, 5, 0, 0);
        idle(3);
        check("reset_data_out", data_out, 0);
        check("reset_out_valid", out_valid, 0);

        // DC gain, R=8, shift=15
        cfg(8, 15);
        obs_t.delete(); obs_d.delete();
        run(96, 100, 1);
        idle(10);
        chk_obs("dc", 7, 100, 8);
        check("dc_sat", sat_flag, 0);

        // Single impulse, R=4, shift=0
        cfg(4, 0);
        obs_t.delete(); obs_d.delete();
        c0 = cyc;
        run(24, 0, 1);
        run(1, 1, 1);
        run(39, 0, 1);
        idle(10);
        check("imp_count", obs_d.size(), 11);
        if (obs_t.size() > 0) check("imp_latency", obs_t[0], c0 + 30);
        foreach (obs_d[i]) if (i < 11) check("imp_coef", obs_d[i], imp[i]);

        // Four unit samples covering every phase: coefficients sum to 4^5
        cfg(4, 0);
        obs_t.delete(); obs_d.delete();
        run(24, 0, 1);
        run(4, 1, 1);
        run(36, 0, 1);
        idle(10);
        sum = 0;
        foreach (obs_d[i]) sum += obs_d[i];
        check("imp_sum", sum, 1024);

        // Gapped input, one valid in three
        cfg(8, 15);
        obs_t.delete(); obs_d.delete();
        run(96, 100, 3);
        idle(10);
        chk_obs("gap", 7, 100, 24);

        // Saturation
        cfg(8, 14);
        obs_t.delete(); obs_d.delete();
        run(96, 32767, 1);
        idle(10);
        chk_obs("sat", 7, 32767, 8);
        check("sat_flag_set", sat_flag, 1);
        cfg(8, 14);
        check("sat_flag_clr", sat_flag, 0);

        // Reconfigure mid-stream to dec_ratio=0
        cfg(8, 15);
        obs_t.delete(); obs_d.delete();
        run(52, 100, 1);
        cfg(0, 0);
        check("cfg_err_zero", cfg_err, 1);
        cc = cyc;
        run(20, 100, 1);
        idle(10);
        check("r1_count", obs_d.size(), 15);
        if (obs_t.size() > 0) check("r1_first", obs_t[0], cc + 12);
        foreach (obs_d[i]) check("r1_data", obs_d[i], 100);
        for (int i = 1; i < obs_t.size(); i++) check("r1_spacing", obs_t[i] - obs_t[i-1], 1);
        cfg(100, 0);
        check("cfg_err_big", cfg_err, 1);
        cfg(8, 15);
        check("cfg_err_clr", cfg_err, 0);

        // Reset with tokens in flight
        run(60, 100, 1);
        obs_t.delete(); obs_d.delete();
        step(1, 0, 1, 100, 0, 0);
        idle(N + 2);
        check("rst_no_valid", obs_d.size(), 0);
        check("rst_data_out", data_out, 0);
        check("rst_sat", sat_flag, 0);
        c0 = cyc;
        run(400, 0, 1);
        idle(10);
        check("rst_r64_count", obs_d.size(), 1);
        if (obs_t.size() > 0) check("rst_r64_first", obs_t[0], c0 + 390);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
